// File: rtl/act_pwl_eval.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : act_pwl_eval
// Purpose  : Per-lane piecewise-linear activation (y = slope*x + intercept,
//            saturated) fed by an external LUT, with a credit-guarded FIFO.
// Revision : 1.0
// ============================================================================
module act_pwl_eval #(
    parameter int LANES      = 32,
    parameter int DATA_W     = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int LUT_WIDTH  = 24,
    parameter int SLOPE_FRAC = 10,
    parameter int INTC_SHIFT = 4,
    parameter int LUT_LAT    = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [LANES*DATA_W-1:0]       i_act_dat,
    input  logic                          i_act_vld,
    input  logic                          i_act_bypass,
    output logic                          o_act_rdy,
    output logic [ADDR_WIDTH*LANES-1:0]   o_lut_raddr,
    output logic                          o_lut_rd_en,
    input  logic [LUT_WIDTH*LANES-1:0]    i_lut_dat,
    output logic [LANES*DATA_W-1:0]       o_out_dat,
    output logic                          o_out_vld,
    input  logic                          i_out_rdy
);

    localparam int VEC_W   = LANES * DATA_W;
    localparam int INTC_W  = LUT_WIDTH / 2;
    localparam int SLOPE_W = LUT_WIDTH - INTC_W;
    localparam int PROD_W  = DATA_W + SLOPE_W;
    localparam int C_W     = INTC_W + INTC_SHIFT;
    localparam int SUM_W   = DATA_W + 2;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int TOT_W   = $clog2(FIFO_DEPTH + LUT_LAT + 3) + 1;

    logic                          w_accept;
    logic [ADDR_WIDTH*LANES-1:0]   w_raddr;
    logic [LANES*PROD_W-1:0]       w_m_p;
    logic [LANES*C_W-1:0]          w_m_c;
    logic [VEC_W-1:0]              w_s_y;
    logic [TOT_W-1:0]              w_inflight;
    logic                          w_push;
    logic                          w_pop;

    // Index 0 is stage A; index LUT_LAT lines up with i_lut_dat.
    logic [VEC_W-1:0]              r_px [LUT_LAT+1];
    logic [LUT_LAT:0]              r_pvld;
    logic [LUT_LAT:0]              r_pbyp;
    logic [ADDR_WIDTH*LANES-1:0]   r_raddr;
    logic                          r_mvld;
    logic [LANES*PROD_W-1:0]       r_mp;
    logic [LANES*C_W-1:0]          r_mc;
    logic [VEC_W-1:0]              r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              r_wr;
    logic [PTR_W-1:0]              r_rd;
    logic [CNT_W-1:0]              r_cnt;

    assign w_accept = i_act_vld & o_act_rdy;

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic signed [DATA_W-1:0]  w_x;
            logic [SLOPE_W-1:0]        w_slope;
            logic [INTC_W-1:0]         w_intc;
            logic signed [PROD_W-1:0]  w_xe;
            logic signed [PROD_W-1:0]  w_se;
            logic signed [PROD_W-1:0]  w_p;
            logic [C_W-1:0]            w_c;
            logic [C_W-1:0]            w_mc;
            logic [SUM_W-1:0]          w_sh;
            logic [SUM_W-1:0]          w_sum;
            logic                      w_ovf;

            assign w_raddr[l*ADDR_WIDTH +: ADDR_WIDTH] =
                {~i_act_dat[l*DATA_W + DATA_W-1], i_act_dat[l*DATA_W + DATA_W-2 -: ADDR_WIDTH-1]};

            assign w_x     = r_px[LUT_LAT][l*DATA_W +: DATA_W];
            assign w_slope = i_lut_dat[l*LUT_WIDTH + INTC_W +: SLOPE_W];
            assign w_intc  = i_lut_dat[l*LUT_WIDTH +: INTC_W];
            assign w_xe    = {{SLOPE_W{w_x[DATA_W-1]}}, w_x};
            assign w_se    = {{DATA_W{w_slope[SLOPE_W-1]}}, w_slope};
            assign w_c     = {{INTC_SHIFT{w_intc[INTC_W-1]}}, w_intc} << INTC_SHIFT;

            // Bypass reuses the datapath: x scaled by 1.0 with zero intercept gives y = x exactly.
            assign w_m_p[l*PROD_W +: PROD_W] = r_pbyp[LUT_LAT] ? (w_xe <<< SLOPE_FRAC) : (w_xe * w_se);
            assign w_m_c[l*C_W +: C_W]       = r_pbyp[LUT_LAT] ? '0 : w_c;

            assign w_p   = r_mp[l*PROD_W +: PROD_W];
            assign w_mc  = r_mc[l*C_W +: C_W];
            assign w_sh  = SUM_W'(w_p >>> SLOPE_FRAC);
            assign w_sum = w_sh + {{(SUM_W-C_W){w_mc[C_W-1]}}, w_mc};
            assign w_ovf = ~((&w_sum[SUM_W-1:DATA_W-1]) | ~(|w_sum[SUM_W-1:DATA_W-1]));

            assign w_s_y[l*DATA_W +: DATA_W] = w_ovf ?
                {w_sum[SUM_W-1], {(DATA_W-1){~w_sum[SUM_W-1]}}} : w_sum[DATA_W-1:0];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pvld  <= '0;
            r_pbyp  <= '0;
            r_raddr <= '0;
            for (int i = 0; i <= LUT_LAT; i++) begin
                r_px[i] <= '0;
            end
            r_mvld  <= 1'b0;
            r_mp    <= '0;
            r_mc    <= '0;
        end else begin
            r_pvld[0] <= w_accept;
            if (w_accept) begin
                r_px[0]   <= i_act_dat;
                r_pbyp[0] <= i_act_bypass;
                r_raddr   <= w_raddr;
            end
            for (int i = 1; i <= LUT_LAT; i++) begin
                r_pvld[i] <= r_pvld[i-1];
                r_pbyp[i] <= r_pbyp[i-1];
                r_px[i]   <= r_px[i-1];
            end
            r_mvld <= r_pvld[LUT_LAT];
            if (r_pvld[LUT_LAT]) begin
                r_mp <= w_m_p;
                r_mc <= w_m_c;
            end
        end
    end

    assign w_push = r_mvld;
    assign w_pop  = (r_cnt != '0) & i_out_rdy;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_s_y;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= (r_wr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= (r_rd == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_rd + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_comb begin
        w_inflight = TOT_W'(r_mvld);
        for (int i = 0; i <= LUT_LAT; i++) begin
            w_inflight = w_inflight + TOT_W'(r_pvld[i]);
        end
    end

    // Gated by i_rst_n so ready reads 0 while reset is held, 1 right after release.
    assign o_act_rdy   = i_rst_n & ((TOT_W'(r_cnt) + w_inflight) < TOT_W'(FIFO_DEPTH));
    assign o_lut_raddr = r_raddr;
    assign o_lut_rd_en = r_pvld[0];
    assign o_out_vld   = (r_cnt != '0);
    assign o_out_dat   = (r_cnt != '0) ? r_mem[r_rd] : '0;

endmodule
`default_nettype wire

// File: tb/tb_act_pwl_eval.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_act_pwl_eval
// Purpose  : Scoreboard bench for act_pwl_eval with a behavioural LUT/PWL model.
// Revision : 1.0
// ============================================================================
module tb_act_pwl_eval;

    localparam int LANES  = 32;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int LUT_W  = 24;
    localparam int VW     = LANES * DATA_W;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n = 1'b0;
    logic [VW-1:0]          i_act_dat = '0;
    logic                   i_act_vld = 1'b0;
    logic                   i_act_bypass = 1'b0;
    logic                   o_act_rdy;
    logic [ADDR_W*LANES-1:0] o_lut_raddr;
    logic                   o_lut_rd_en;
    logic [LUT_W*LANES-1:0] i_lut_dat = '0;
    logic [VW-1:0]          o_out_dat;
    logic                   o_out_vld;
    logic                   i_out_rdy = 1'b0;

    logic [LUT_W-1:0]       lut_tab [LANES][16];
    logic [VW-1:0]          exp_q [$];
    int                     n_cmp = 0;
    int                     n_fail = 0;

    always #5 i_clk = ~i_clk;

    act_pwl_eval dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_act_dat    (i_act_dat),
        .i_act_vld    (i_act_vld),
        .i_act_bypass (i_act_bypass),
        .o_act_rdy    (o_act_rdy),
        .o_lut_raddr  (o_lut_raddr),
        .o_lut_rd_en  (o_lut_rd_en),
        .i_lut_dat    (i_lut_dat),
        .o_out_dat    (o_out_dat),
        .o_out_vld    (o_out_vld),
        .i_out_rdy    (i_out_rdy)
    );

    // Synchronous LUT memory with one cycle of read latency.
    always @(posedge i_clk) begin
        if (o_lut_rd_en) begin
            for (int l = 0; l < LANES; l++) begin
                i_lut_dat[l*LUT_W +: LUT_W] <= lut_tab[l][o_lut_raddr[l*ADDR_W +: ADDR_W]];
            end
        end
    end

    function automatic logic [DATA_W-1:0] ref_lane(input int l, input logic [DATA_W-1:0] xd, input logic byp);
        int          x;
        int          seg;
        logic [23:0] e;
        int          slope;
        int          intc;
        longint      prod;
        longint      q;
        longint      y;
        logic [63:0] yy;
        x     = $signed(xd);
        seg   = (x + 32768) / 4096;
        e     = lut_tab[l][seg];
        slope = $signed(e[23:12]);
        intc  = $signed(e[11:0]);
        prod  = longint'(x) * longint'(slope);
        q     = prod / 1024;
        if (prod < 0 && (prod % 1024) != 0) q = q - 1;
        y     = byp ? longint'(x) : q + longint'(intc) * 16;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        yy = y;
        return yy[DATA_W-1:0];
    endfunction

    function automatic logic [VW-1:0] ref_vec(input logic [VW-1:0] d, input logic byp);
        logic [VW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*DATA_W +: DATA_W] = ref_lane(l, d[l*DATA_W +: DATA_W], byp);
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*DATA_W +: DATA_W] = 16'($urandom);
        return v;
    endfunction

    function automatic logic [VW-1:0] fill_vec(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [VW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*DATA_W +: DATA_W] = (l % 2 == 0) ? a : b;
        return v;
    endfunction

    task automatic set_lut_uniform(input logic [11:0] slope, input logic [11:0] intc);
        for (int l = 0; l < LANES; l++)
            for (int s = 0; s < 16; s++) lut_tab[l][s] = {slope, intc};
    endtask

    task automatic set_lut_random();
        for (int l = 0; l < LANES; l++)
            for (int s = 0; s < 16; s++) lut_tab[l][s] = 24'($urandom);
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [VW-1:0] d, input logic byp,
                         input logic ordy, output logic acc);
        @(negedge i_clk);
        i_act_vld    = vld;
        i_act_dat    = d;
        i_act_bypass = byp;
        i_out_rdy    = ordy;
        #1;
        acc = vld && o_act_rdy && i_rst_n;
        if (acc) exp_q.push_back(ref_vec(d, byp));
    endtask

    task automatic drain();
        logic acc;
        int   k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            drive(1'b0, rand_vec(), 1'b0, 1'b1, acc);
            k++;
        end
        drive(1'b0, rand_vec(), 1'b0, 1'b1, acc);
        chk("drain_left", exp_q.size(), 0);
        chk("drain_empty", o_out_vld, 0);
    endtask

    // Monitor: pops one expected vector for every handshake the DUT presents.
    initial begin
        logic [VW-1:0] e;
        forever begin
            @(negedge i_clk);
            #2;
            if (i_rst_n && o_out_vld && i_out_rdy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got %h expected none", o_out_dat);
                end else begin
                    e = exp_q.pop_front();
                    if (o_out_dat !== e) begin
                        n_fail++;
                        $display("FAIL out_dat: got %h expected %h", o_out_dat, e);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic          acc;
        int            nacc;
        int            idx;
        logic [VW-1:0] d;
        logic [VW-1:0] vecs [12];
        logic          byps [12];

        // Reset state
        #1;
        chk("rst_out_vld", o_out_vld, 0);
        chk("rst_out_dat", (o_out_dat == '0), 1);
        chk("rst_act_rdy", o_act_rdy, 0);
        chk("rst_rd_en", o_lut_rd_en, 0);
        chk("rst_raddr", (o_lut_raddr == '0), 1);
        repeat (3) @(negedge i_clk);
        #3 i_rst_n = 1'b1;
        #1 chk("rdy_after_release", o_act_rdy, 1);

        // Unity slope, latency and address of a single vector
        set_lut_uniform(12'h400, 12'h000);
        d = rand_vec();
        d[15:0] = 16'h1234;
        drive(1'b1, d, 1'b0, 1'b0, acc);
        chk("basic_accept", acc, 1);
        drive(1'b0, d, 1'b0, 1'b0, acc);
        chk("basic_rd_en", o_lut_rd_en, 1);
        chk("basic_raddr0", o_lut_raddr[3:0], 4'h9);
        chk("basic_vld_k1", o_out_vld, 0);
        drive(1'b0, d, 1'b0, 1'b0, acc);
        chk("basic_rd_en_off", o_lut_rd_en, 0);
        chk("basic_vld_k2", o_out_vld, 0);
        drive(1'b0, d, 1'b0, 1'b0, acc);
        chk("basic_vld_k3", o_out_vld, 0);
        drive(1'b0, d, 1'b0, 1'b0, acc);
        chk("basic_vld_k4", o_out_vld, 1);
        chk("basic_lane0", o_out_dat[15:0], 16'h1234);
        drain();

        // Address mapping boundaries and single-cycle read enable
        d = rand_vec();
        d[15:0]  = 16'h8000;
        d[31:16] = 16'h0000;
        d[47:32] = 16'h7FFF;
        drive(1'b1, d, 1'b0, 1'b1, acc);
        drive(1'b0, d, 1'b0, 1'b1, acc);
        chk("addr_lane0", o_lut_raddr[3:0], 0);
        chk("addr_lane1", o_lut_raddr[7:4], 8);
        chk("addr_lane2", o_lut_raddr[11:8], 15);
        chk("addr_rd_en", o_lut_rd_en, 1);
        drive(1'b0, d, 1'b0, 1'b1, acc);
        chk("addr_rd_en_pulse", o_lut_rd_en, 0);
        chk("addr_hold_lane2", o_lut_raddr[11:8], 15);
        drain();

        // Saturation and intercept-only paths
        set_lut_uniform(12'h7FF, 12'h000);
        drive(1'b1, fill_vec(16'h7000, 16'h9000), 1'b0, 1'b1, acc);
        drain();
        set_lut_uniform(12'h000, 12'h100);
        drive(1'b1, rand_vec(), 1'b0, 1'b1, acc);
        drain();

        // Credit limit with a stalled consumer
        set_lut_random();
        for (int i = 0; i < 12; i++) begin
            vecs[i] = rand_vec();
            byps[i] = 1'($urandom);
        end
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[idx], byps[idx], 1'b0, acc);
            if (acc) idx++;
        end
        chk("credit_accepts", idx, 8);
        chk("credit_rdy_low", o_act_rdy, 0);
        for (int i = 0; i < 60 && idx < 12; i++) begin
            drive(1'b1, vecs[idx], byps[idx], 1'b1, acc);
            if (acc) idx++;
        end
        chk("credit_all_sent", idx, 12);
        drain();

        // Bypass interleaved with LUT vectors at full rate
        set_lut_uniform(12'h7FF, 12'h000);
        nacc = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, fill_vec(16'h0100, 16'h0100), 1'((i + 1) % 2), 1'b1, acc);
            if (acc) nacc++;
        end
        chk("full_rate", nacc, 16);
        drain();

        // Randomised traffic and back-pressure
        set_lut_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), rand_vec(), 1'($urandom), ($urandom_range(0, 3) != 0), acc);
        end
        drain();

        // Reset with vectors in flight
        set_lut_uniform(12'h400, 12'h000);
        for (int i = 0; i < 3; i++) drive(1'b1, rand_vec(), 1'b0, 1'b0, acc);
        drive(1'b0, rand_vec(), 1'b0, 1'b0, acc);
        drive(1'b0, rand_vec(), 1'b0, 1'b0, acc);
        chk("pre_rst_vld", o_out_vld, 1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", o_out_vld, 0);
        chk("mid_rst_dat", (o_out_dat == '0), 1);
        chk("mid_rst_rd_en", o_lut_rd_en, 0);
        chk("mid_rst_rdy", o_act_rdy, 0);
        exp_q.delete();
        drive(1'b0, rand_vec(), 1'b0, 1'b1, acc);
        drive(1'b0, rand_vec(), 1'b0, 1'b1, acc);
        @(negedge i_clk);
        #3 i_rst_n = 1'b1;
        #1 chk("post_rst_rdy", o_act_rdy, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, rand_vec(), 1'b0, 1'b1, acc);
            chk("post_rst_quiet", o_out_vld, 0);
        end
        drive(1'b1, rand_vec(), 1'b0, 1'b1, acc);
        chk("post_rst_accept", acc, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
